delay_arbiter: RTL

DELAY_ARBITER -- requirements
Module: delay_arbiter

---
 rtl/delay_arbiter_pkg.sv | 42 ++++
 rtl/delay_sat_step.sv | 51 +++++
 rtl/delay_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/delay_arbiter_pkg.sv
// Shared definitions for the delay arbiter: register map, STATUS/CONTROL bit
// positions, datapath widths and the write-one-to-clear update helper.
package delay_arbiter_pkg;

    // Width of the blink delay value driven to the blinker.
    localparam int DELAY_W    = 4;
    // Avalon-MM data bus width.
    localparam int DATA_W     = 32;
    // Width of the accepted-key-pulse counter.
    localparam int KEYCOUNT_W = 16;
    // Number of implemented STATUS and CONTROL bits.
    localparam int STATUS_W   = 3;
    localparam int CONTROL_W  = 2;

    // Avalon-MM word addresses of the four registers.
    typedef enum logic [1:0] {
        REG_DELAY    = 2'd0,
        REG_STATUS   = 2'd1,
        REG_KEYCOUNT = 2'd2,
        REG_CONTROL  = 2'd3
    } reg_addr_e;

    // STATUS bit positions (all write-one-to-clear).
    localparam int ST_KEY_EVT = 0;
    localparam int ST_SAT     = 1;
    localparam int ST_DROP    = 2;

    // CONTROL bit positions.
    localparam int CTL_KEY_LOCK = 0;
    localparam int CTL_IRQ_EN   = 1;

    // Write-one-to-clear with set priority: a bit being set in the same cycle
    // that software clears it stays set, so no event is ever lost.
    function automatic logic [STATUS_W-1:0] w1c_update(
        input logic [STATUS_W-1:0] cur,
        input logic [STATUS_W-1:0] clr,
        input logic [STATUS_W-1:0] set
    );
        return (cur & ~clr) | set;
    endfunction

endpackage

// File: rtl/delay_sat_step.sv
// Combinational next-delay calculator: either loads a software value clamped
// into [MIN_DELAY, MAX_DELAY], or steps the current delay by +/-1 with
// saturation at the same bounds. Flags whenever a bound limited the result.
module delay_sat_step
    import delay_arbiter_pkg::*;
#(
    parameter int unsigned MIN_DELAY = 1,
    parameter int unsigned MAX_DELAY = 15
) (
    input  logic [DELAY_W-1:0] cur_delay,
    input  logic               load_en,
    input  logic [DELAY_W-1:0] load_value,
    input  logic               step_up,
    input  logic               step_down,
    output logic [DELAY_W-1:0] next_delay,
    output logic               saturated
);

    localparam logic [DELAY_W-1:0] MIN_D = DELAY_W'(MIN_DELAY);
    localparam logic [DELAY_W-1:0] MAX_D = DELAY_W'(MAX_DELAY);

    // Load has priority over stepping; opposing step requests cancel.
    always_comb begin
        next_delay = cur_delay;
        saturated  = 1'b0;
        if (load_en) begin
            if (load_value < MIN_D) begin
                next_delay = MIN_D;
                saturated  = 1'b1;
            end else if (load_value > MAX_D) begin
                next_delay = MAX_D;
                saturated  = 1'b1;
            end else begin
                next_delay = load_value;
            end
        end else if (step_up && !step_down) begin
            if (cur_delay >= MAX_D) begin
                saturated = 1'b1;
            end else begin
                next_delay = cur_delay + DELAY_W'(1);
            end
        end else if (step_down && !step_up) begin
            if (cur_delay <= MIN_D) begin
                saturated = 1'b1;
            end else begin
                next_delay = cur_delay - DELAY_W'(1);
            end
        end
    end

endmodule

// File: rtl/delay_arbiter.sv
// Delay arbiter: merges push-key speed requests (faster/slower) with HPS
// register writes into one saturating blink delay, counts accepted key
// pulses and raises a level interrupt on key activity or dropped keys.
//
// Avalon-MM handshake: there is no waitrequest, so every avs_read/avs_write
// strobe is accepted in the cycle it is seen. A read returns data sampled
// from the register state before that clock edge, qualified by
// avs_readdatavalid exactly one cycle later; a read and write in the same
// cycle both take effect and the read returns the old value.
module delay_arbiter
    import delay_arbiter_pkg::*;
#(
    parameter int unsigned RESET_DELAY = 8,
    parameter int unsigned MIN_DELAY   = 1,
    parameter int unsigned MAX_DELAY   = 15
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               faster,
    input  logic               slower,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [DATA_W-1:0]  avs_writedata,
    output logic [DATA_W-1:0]  avs_readdata,
    output logic               avs_readdatavalid,
    output logic [DELAY_W-1:0] delay,
    output logic               irq
);

    localparam logic [DELAY_W-1:0] RESET_D = DELAY_W'(RESET_DELAY);

    // Register state
    logic [DELAY_W-1:0]    delay_q,         delay_d;
    logic [STATUS_W-1:0]   status_q,        status_d;
    logic [KEYCOUNT_W-1:0] keycount_q,      keycount_d;
    logic [CONTROL_W-1:0]  control_q,       control_d;
    logic [DATA_W-1:0]     readdata_q,      readdata_d;
    logic                  readdatavalid_q, readdatavalid_d;
    logic                  irq_q,           irq_d;

    // Decode and arbitration
    reg_addr_e             addr_e;
    logic                  wr_delay;
    logic                  wr_status;
    logic                  wr_control;
    logic                  key_req;
    logic                  key_apply;
    logic                  key_drop;
    logic [DELAY_W-1:0]    step_delay;
    logic                  step_sat;
    logic [STATUS_W-1:0]   status_set;
    logic [STATUS_W-1:0]   status_clr;
    logic [DATA_W-1:0]     rdata_mux;

    // Upper write-data bits have no register behind them.
    logic                  unused_wdata;
    assign unused_wdata = ^avs_writedata[DATA_W-1:DELAY_W];

    // Decode bus writes and arbitrate key pulses against DELAY writes.
    always_comb begin
        addr_e     = reg_addr_e'(avs_address);
        wr_delay   = avs_write && (addr_e == REG_DELAY);
        wr_status  = avs_write && (addr_e == REG_STATUS);
        wr_control = avs_write && (addr_e == REG_CONTROL);
        // Opposing pulses cancel; a locked keypad produces no request at all.
        key_req    = (faster ^ slower) && !control_q[CTL_KEY_LOCK];
        // A software DELAY write in the same cycle takes precedence.
        key_apply  = key_req && !wr_delay;
        key_drop   = key_req && wr_delay;
    end

    delay_sat_step #(
        .MIN_DELAY (MIN_DELAY),
        .MAX_DELAY (MAX_DELAY)
    ) u_sat_step (
        .cur_delay  (delay_q),
        .load_en    (wr_delay),
        .load_value (avs_writedata[DELAY_W-1:0]),
        .step_up    (key_apply && slower),
        .step_down  (key_apply && faster),
        .next_delay (step_delay),
        .saturated  (step_sat)
    );

    // Next-state for delay, STATUS, KEYCOUNT, CONTROL and irq.
    always_comb begin
        delay_d = step_delay;

        status_set             = '0;
        status_set[ST_KEY_EVT] = key_apply;
        status_set[ST_SAT]     = step_sat;
        status_set[ST_DROP]    = key_drop;
        status_clr             = wr_status ? avs_writedata[STATUS_W-1:0] : '0;
        status_d               = w1c_update(status_q, status_clr, status_set);

        // Saturated pulses still count; KEYCOUNT ignores bus writes and wraps.
        keycount_d = keycount_q;
        if (key_apply) begin
            keycount_d = keycount_q + KEYCOUNT_W'(1);
        end

        control_d = control_q;
        if (wr_control) begin
            control_d = avs_writedata[CONTROL_W-1:0];
        end

        // Interrupt follows the registered flags, one cycle behind them.
        irq_d = control_q[CTL_IRQ_EN] &&
                (status_q[ST_KEY_EVT] || status_q[ST_DROP]);
    end

    // Read mux over pre-edge register state; unimplemented bits read 0.
    always_comb begin
        rdata_mux = '0;
        case (addr_e)
            REG_DELAY:    rdata_mux = DATA_W'(delay_q);
            REG_STATUS:   rdata_mux = DATA_W'(status_q);
            REG_KEYCOUNT: rdata_mux = DATA_W'(keycount_q);
            REG_CONTROL:  rdata_mux = DATA_W'(control_q);
            default:      rdata_mux = '0;
        endcase
        readdata_d      = avs_read ? rdata_mux : '0;
        readdatavalid_d = avs_read;
    end

    // Delay and register-file state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            delay_q    <= RESET_D;
            status_q   <= '0;
            keycount_q <= '0;
            control_q  <= '0;
        end else begin
            delay_q    <= delay_d;
            status_q   <= status_d;
            keycount_q <= keycount_d;
            control_q  <= control_d;
        end
    end

    // Registered read response; reset discards any read in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata_q      <= '0;
            readdatavalid_q <= 1'b0;
        end else begin
            readdata_q      <= readdata_d;
            readdatavalid_q <= readdatavalid_d;
        end
    end

    // Registered interrupt output.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign delay             = delay_q;
    assign avs_readdata      = readdata_q;
    assign avs_readdatavalid = readdatavalid_q;
    assign irq               = irq_q;

endmodule
